// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry skid buffer between the ALU and writeback.
// Ports: clock, reset_n (async active-low), flush; upstream in_valid/in_ready
// with in_result, in_ovf, in_rd, in_op; downstream out_valid/out_ready with
// out_data, out_rd, out_we, out_exc; ovf_count counts exceptions delivered.
// Macro ALU_OVF_EXC_EN turns overflowing add/addi/sub results into
// exception entries (rd 30, data = op code) and enables ovf_count.
`timescale 1ns/1ps
module alu_result_buffer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_ovf,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_exc,
  output logic [7:0]  ovf_count
);
  logic [38:0] head_q, skid_q, new_e;
  logic        head_v, skid_v, push, pop, n_exc;
  logic [31:0] n_data;
  logic [4:0]  n_rd;
`ifdef ALU_OVF_EXC_EN
  logic [7:0] cnt_q;
  assign n_exc  = in_ovf && in_op != 2'b00;
  assign n_rd   = n_exc ? 5'd30 : in_rd;
  assign n_data = n_exc ? {30'd0, in_op} : in_result;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= 8'd0;
    else if (!flush && pop && head_q[38] && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
  assign ovf_count = cnt_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{in_ovf, in_op};
  assign n_exc      = 1'b0;
  assign n_rd       = in_rd;
  assign n_data     = in_result;
  assign ovf_count  = 8'd0;
`endif
  // entry layout: {exc, we, rd, data}; we is resolved at capture
  assign new_e = {n_exc, (n_rd != 5'd0) || n_exc, n_rd, n_data};
  assign push  = in_valid && in_ready;
  assign pop   = head_v && out_ready;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop && skid_v) begin
      head_q <= skid_q;
      skid_v <= 1'b0;
    end else if (push && (pop || !head_v)) begin
      head_q <= new_e;
      head_v <= 1'b1;
    end else if (push) begin
      skid_q <= new_e;
      skid_v <= 1'b1;
    end else if (pop) begin
      head_v <= 1'b0;
    end
  // push is only possible with the skid empty, so the skid->head move never races a push
  assign in_ready  = !skid_v;
  assign out_valid = head_v;
  assign {out_exc, out_we, out_rd, out_data} = head_q;
endmodule
